sram_like_arbiter: RTL
======================

Name: sram_like_arbiter

Overview:
- Sits directly downstream of mycpu_top's memory ports, once the fetch and MEM stages move to a sram-like handshake (req / addr_ok / data_ok).
- Merges the instruction-side and data-side requests onto a single sram-like slave port in front of the unified memory or bus bridge.
- Strictly one transaction in flight. Data side has fixed priority over instruction side.
- Each response is routed back to the master that issued the request.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction-side request valid
- inst_wr  in  1  instruction-side write (normally 0)
- inst_size  in  2  access size: 0=byte, 1=half, 2=word
- inst_addr  in  ADDR_W  instruction-side address
- inst_wdata  in  DATA_W  instruction-side write data
- inst_addr_ok  out  1  instruction request accepted
- inst_data_ok  out  1  instruction response valid
- inst_rdata  out  DATA_W  instruction read data
- data_req  in  1  data-side request valid
- data_wr  in  1  data-side write
- data_size  in  2  data-side size
- data_addr  in  ADDR_W  data-side address
- data_wdata  in  DATA_W  data-side write data
- data_addr_ok  out  1  data request accepted
- data_data_ok  out  1  data response valid
- data_rdata  out  DATA_W  data read data
- m_req  out  1  slave-side request valid
- m_wr  out  1  slave-side write
- m_size  out  2  slave-side size
- m_addr  out  ADDR_W  slave-side address
- m_wdata  out  DATA_W  slave-side write data
- m_addr_ok  in  1  slave accepted request
- m_data_ok  in  1  slave response valid
- m_rdata  in  DATA_W  slave read data

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE, owner=0. All outputs are 0, including m_req and every addr_ok/data_ok.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If data_req=1, latch data_wr/size/addr/wdata into the request register, set owner=DATA, go to REQ.
  - Else if inst_req=1, latch the instruction-side fields, set owner=INST, go to REQ.
  - Else stay in IDLE.
  - The latch cycle is the master's acceptance: the selected master's addr_ok=1 combinationally in that IDLE cycle. The other master's addr_ok=0.
- REQ:
  - m_req=1, with m_wr/size/addr/wdata driven from registers.
  - On m_addr_ok=1, go to WAIT.
  - Registered fields hold stable until m_addr_ok.
- WAIT:
  - m_req=0.
  - On m_data_ok=1, pulse the owner's data_ok for exactly that cycle and pass m_rdata to the owner's rdata combinationally. Go to IDLE.
  - The non-owner's data_ok stays 0.
  - Writes also return a data_ok.
- Minimum latency, req to data_ok: 3 cycles (IDLE accept, REQ with addr_ok, WAIT with data_ok).
- The next request can be accepted in the cycle after data_ok.
- No addr_ok is given to either master while in REQ or WAIT. Masters hold req and fields until addr_ok.
- Simultaneous inst_req and data_req in IDLE: data wins; inst stays pending and is served next.
- Starvation: none required. The data side is bursty by construction of the pipeline.
- m_data_ok while in IDLE or REQ is a protocol error. Ignore it and drive no data_ok.
- m_addr_ok while in IDLE or WAIT: ignore it.
- Reset mid-transaction returns to IDLE immediately. An outstanding slave response is then lost; the slave is reset together with the arbiter.
- inst_rdata and data_rdata equal m_rdata whenever the corresponding data_ok=1, and are don't-care otherwise.

Test Plan:
- Single inst read:
  - Stimulus: inst_req=1, addr=0xBFC00000, size=2; slave gives addr_ok in the 1st REQ cycle and data_ok 2 cycles later with rdata=0x3C010001.
  - Response: inst_addr_ok at cycle 0, m_req high 1 cycle with m_addr=0xBFC00000, inst_data_ok one pulse carrying 0x3C010001, data_data_ok never asserts.
- Simultaneous requests:
  - Stimulus: inst_req and data_req (write, addr=0x80001000, wdata=0xDEADBEEF, size=2) both high in IDLE.
  - Response: data accepted first, m_wr=1, data_data_ok returned; then the inst request is accepted the cycle after, with inst_addr_ok.
- Slave backpressure:
  - Stimulus: m_addr_ok held 0 for 5 cycles.
  - Response: m_req and m_addr/wdata stay stable for all 5 cycles; no new master addr_ok during that time.
- Byte store:
  - Stimulus: data_req, wr=1, size=0, addr=0x80000003.
  - Response: m_size=0, m_addr=0x80000003 passed unmodified.
- Reset in WAIT:
  - Stimulus: deassert resetn while waiting for data_ok.
  - Response: all outputs 0 within the same cycle (asynchronous); after release, state is IDLE and a new inst request completes normally.
- Spurious response:
  - Stimulus: m_data_ok=1 while in IDLE.
  - Response: no data_ok pulse on either master port.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// Two-master to one-slave sram-like arbiter: data side has fixed priority,
// one transaction in flight, response routed back to the issuing master.
module sram_like_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic inst_addr_ok_c, data_addr_ok_c;

  // State and request register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      owner_q <= OWNER_INST;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state, acceptance and response routing
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wr_d           = wr_q;
    size_d         = size_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    inst_addr_ok_c = 1'b0;
    data_addr_ok_c = 1'b0;
    inst_data_ok   = 1'b0;
    data_data_ok   = 1'b0;
    m_req          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (data_req) begin
          wr_d           = data_wr;
          size_d         = data_size;
          addr_d         = data_addr;
          wdata_d        = data_wdata;
          owner_d        = OWNER_DATA;
          data_addr_ok_c = 1'b1;
          state_d        = ST_REQ;
        end else if (inst_req) begin
          wr_d           = inst_wr;
          size_d         = inst_size;
          addr_d         = inst_addr;
          wdata_d        = inst_wdata;
          owner_d        = OWNER_INST;
          inst_addr_ok_c = 1'b1;
          state_d        = ST_REQ;
        end
      end
      ST_REQ: begin
        m_req = 1'b1;
        if (m_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (m_data_ok) begin
          inst_data_ok = (owner_q == OWNER_INST);
          data_data_ok = (owner_q == OWNER_DATA);
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Acceptance is combinational on the master inputs, so mask it while in reset
  assign inst_addr_ok = inst_addr_ok_c & resetn;
  assign data_addr_ok = data_addr_ok_c & resetn;

  assign m_wr    = wr_q;
  assign m_size  = size_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

  assign inst_rdata = inst_data_ok ? m_rdata : '0;
  assign data_rdata = data_data_ok ? m_rdata : '0;

endmodule
